// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-channel valid/ready multiplexer.
package mux_arb_pkg;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// Rotating priority encoder: first requester strictly after ptr, wrapping modulo N.
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N    = 32,
   parameter int SELW = 5
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            found,
   output logic [SELW-1:0] idx
);

   // One extra bit so ptr+offset cannot wrap before the modulo-N fold.
   logic [SELW:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = {1'b0, ptr} + (SELW+1)'(i);
         if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
         if (!found && req[cand[SELW-1:0]]) begin
            found = 1'b1;
            idx   = cand[SELW-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel W-bit multiplexer with addressed or round-robin grant and a
// single registered output slot that is handed over with valid/ready.
module mux_arb_n
   import mux_arb_pkg::*;
#(
   parameter int N    = 32,
   parameter int W    = 32,
   parameter int SELW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_chan,
   output logic              out_valid,
   input  logic              out_ready
);

   // Valid/ready: a beat moves when valid and ready are both high in the same
   // cycle; in_ready is one-hot on the granted channel and never waits on in_valid
   // of other channels, out_valid never depends on out_ready.

   if (SELW < clog2(N)) begin : g_selw_check
      $error("mux_arb_n: SELW too narrow for N");
   end

   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q,  out_data_d;
   logic [SELW-1:0] out_chan_q,  out_chan_d;
   logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

   logic            slot_free;
   logic            rr_found;
   logic [SELW-1:0] rr_idx;
   logic            addr_found;
   logic            cand_found;
   logic [SELW-1:0] cand_idx;
   logic            grant;

   rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
      .req   (in_valid),
      .ptr   (rr_ptr_q),
      .found (rr_found),
      .idx   (rr_idx)
   );

   assign slot_free = !out_valid_q || out_ready;

   // Out-of-range sel (possible when N is not a power of two) never grants.
   always_comb begin
      addr_found = 1'b0;
      if ({1'b0, sel} < (SELW+1)'(N)) addr_found = in_valid[sel];
   end

   assign cand_found = (mode == MODE_RR) ? rr_found : addr_found;
   assign cand_idx   = (mode == MODE_RR) ? rr_idx   : sel;
   assign grant      = !rst && en && slot_free && cand_found;

   always_comb begin
      in_ready = '0;
      if (grant) in_ready[cand_idx] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[cand_idx*W +: W];
         out_chan_d  = cand_idx;
         if (mode == MODE_RR) rr_ptr_d = cand_idx;
      end else if (slot_free) begin
         out_valid_d = 1'b0;
      end
   end

   // rr_ptr resets to N-1 so the first round-robin search starts at channel 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_ptr_q    <= SELW'(N-1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: a 32-channel and a 24-channel instance share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_mux_arb_n;

   localparam int NA   = 32;
   localparam int NB   = 24;
   localparam int W    = 32;
   localparam int SELW = 5;

   // ---------------- clock / reset / stimulus signals ----------------
   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            mode;
   logic [SELW-1:0] sel;
   logic [31:0]     valid;
   logic            out_ready;
   logic [W-1:0]    lane [32];

   logic [NA*W-1:0] in_data_a;
   logic [NB*W-1:0] in_data_b;
   logic [NA-1:0]   in_ready_a;
   logic [NB-1:0]   in_ready_b;
   logic [W-1:0]    out_data_a, out_data_b;
   logic [SELW-1:0] out_chan_a, out_chan_b;
   logic            out_valid_a, out_valid_b;

   always #5 clk = ~clk;

   always_comb begin
      in_data_a = '0;
      in_data_b = '0;
      for (int k = 0; k < NA; k++) in_data_a[k*W +: W] = lane[k];
      for (int k = 0; k < NB; k++) in_data_b[k*W +: W] = lane[k];
   end

   mux_arb_n #(.N(NA), .W(W), .SELW(SELW)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .in_data(in_data_a), .in_valid(valid[NA-1:0]), .in_ready(in_ready_a),
      .out_data(out_data_a), .out_chan(out_chan_a), .out_valid(out_valid_a),
      .out_ready(out_ready)
   );

   mux_arb_n #(.N(NB), .W(W), .SELW(SELW)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .in_data(in_data_b), .in_valid(valid[NB-1:0]), .in_ready(in_ready_b),
      .out_data(out_data_b), .out_chan(out_chan_b), .out_valid(out_valid_b),
      .out_ready(out_ready)
   );

   // ---------------- reference model + scoreboard ----------------
   int           tests = 0;
   int           fails = 0;
   bit           m_valid [2];
   logic [W-1:0] m_data  [2];
   int           m_chan  [2];
   int           m_ptr   [2];
   logic [W-1:0] exp_qa [$];
   logic [W-1:0] exp_qb [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = '0;
         m_chan[i]  = 0;
      end
      m_ptr[0] = NA - 1;
      m_ptr[1] = NB - 1;
      exp_qa.delete();
      exp_qb.delete();
   endtask

   task automatic model_pick(input int inst, input int n, output bit found, output int idx);
      found = 1'b0;
      idx   = 0;
      if (rst || !en || (m_valid[inst] && !out_ready)) return;
      if (mode == 1'b0) begin
         if (int'(sel) < n && valid[sel]) begin
            found = 1'b1;
            idx   = int'(sel);
         end
      end else begin
         for (int off = 1; off <= n && !found; off++) begin
            int k;
            k = (m_ptr[inst] + off) % n;
            if (valid[k]) begin
               found = 1'b1;
               idx   = k;
            end
         end
      end
   endtask

   task automatic model_edge(input int inst, input bit found, input int idx);
      if (found) begin
         if (m_valid[inst] && out_ready) begin end
         m_valid[inst] = 1'b1;
         m_data[inst]  = lane[idx];
         m_chan[inst]  = idx;
         if (mode) m_ptr[inst] = idx;
         if (inst == 0) exp_qa.push_back(lane[idx]);
         else           exp_qb.push_back(lane[idx]);
      end else if (!m_valid[inst] || out_ready) begin
         m_valid[inst] = 1'b0;
      end
   endtask

   // One clock: check grants before the edge, consume/compare, advance the model.
   task automatic step();
      bit          fa, fb;
      int          ia, ib;
      logic [31:0] ra, rb;
      #1;
      model_pick(0, NA, fa, ia);
      model_pick(1, NB, fb, ib);
      ra = fa ? (32'd1 << ia) : 32'd0;
      rb = fb ? (32'd1 << ib) : 32'd0;
      chk("in_ready_a", in_ready_a, ra);
      chk("in_ready_b", in_ready_b, rb[NB-1:0]);
      if (m_valid[0] && out_ready && exp_qa.size() > 0) chk("sb_data_a", out_data_a, exp_qa.pop_front());
      if (m_valid[1] && out_ready && exp_qb.size() > 0) chk("sb_data_b", out_data_b, exp_qb.pop_front());
      @(posedge clk);
      model_edge(0, fa, ia);
      model_edge(1, fb, ib);
      #1;
      chk("out_valid_a", out_valid_a, m_valid[0]);
      chk("out_data_a",  out_data_a,  m_data[0]);
      chk("out_chan_a",  out_chan_a,  m_chan[0]);
      chk("out_valid_b", out_valid_b, m_valid[1]);
      chk("out_data_b",  out_data_b,  m_data[1]);
      chk("out_chan_b",  out_chan_b,  m_chan[1]);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid_a", out_valid_a, 0);
      chk("rst_valid_b", out_valid_b, 0);
      chk("rst_data_a",  out_data_a,  0);
      chk("rst_chan_a",  out_chan_a,  0);
      chk("rst_ready_a", in_ready_a,  0);
      chk("rst_ready_b", in_ready_b,  0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic ramp_lanes();
      for (int k = 0; k < 32; k++) lane[k] = k * 32'h0101_0101;
   endtask

   task automatic random_lanes();
      for (int k = 0; k < 32; k++) lane[k] = $urandom;
   endtask

   // ---------------- directed + random sequence ----------------
   int saved;

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; valid = '0; out_ready = 1'b0;
      for (int k = 0; k < 32; k++) lane[k] = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("init_valid_a", out_valid_a, 0);
      chk("init_ready_a", in_ready_a, 0);
      rst = 1'b0;

      // Async reset while a beat is held, then first RR grant is channel 0.
      random_lanes();
      en = 1'b1; mode = 1'b1; valid = '1; out_ready = 1'b0;
      step();
      step();
      #2;
      apply_reset();
      step();
      chk("rst_first_rr_a", out_chan_a, 0);
      chk("rst_first_rr_b", out_chan_b, 0);

      // RR fairness from a fresh reset, including the 24-channel wrap.
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 33; i++) begin
         step();
         chk("rr_seq_a", out_chan_a, i % NA);
         chk("rr_seq_b", out_chan_b, i % NB);
      end
      valid = '0; valid[3] = 1'b1; valid[17] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_pair_a", out_chan_a, (i % 2 == 0) ? 3 : 17);
      end

      // Addressed mode.
      ramp_lanes();
      mode = 1'b0; sel = 5'd5; valid = '1; out_ready = 1'b1;
      #1;
      chk("addr_ready_a", in_ready_a, 32'h20);
      step();
      chk("addr_data_a", out_data_a, 32'h0505_0505);
      chk("addr_chan_a", out_chan_a, 5);

      // Backpressure.
      random_lanes();
      mode = 1'b1; valid = '1; out_ready = 1'b1;
      step();
      saved = m_chan[0];
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_a", out_chan_a, saved);
      end
      out_ready = 1'b1;
      step();
      chk("bp_next_a", out_chan_a, (saved + 1) % NA);

      // Disable: held beat drains, no new grants, then resume from rr_ptr.
      out_ready = 1'b0;
      step();
      en = 1'b0;
      step();
      out_ready = 1'b1;
      step();
      chk("dis_drain_a", out_valid_a, 0);
      step();
      chk("dis_idle_a", out_valid_a, 0);
      saved = m_ptr[0];
      en = 1'b1;
      step();
      chk("dis_resume_a", out_chan_a, (saved + 1) % NA);

      // sel beyond N on the 24-channel instance gives no grant.
      mode = 1'b0; sel = 5'd24;
      step();
      chk("sel_oor_b", out_valid_b, 0);
      chk("sel24_a", out_chan_a, 24);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 7) != 0);
         mode      = 1'($urandom_range(0, 1));
         sel       = SELW'($urandom_range(0, 31));
         valid     = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & $urandom & $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         random_lanes();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
